bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder_pkg.sv | 35 +++
 rtl/bus_mem_responder_resp_pipe.sv | 47 ++++
 rtl/bus_mem_responder.sv | 104 ++++++++++
 tb/tb_bus_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_responder_pkg.sv
// Shared types and helpers for the bus memory responder: grant FSM states,
// the response entry carried down the response pipeline, and byte merging.
package bus_mem_responder_pkg;

  // Deepest response pipeline the responder supports.
  localparam int MaxRespDelay = 4;

  // Grant FSM: IDLE with no request, WAIT while counting toward the grant
  // delay, READY once the count is reached but the grant is being stalled.
  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_WAIT  = 2'd1,
    GNT_READY = 2'd2
  } gnt_state_t;

  // One response slot travelling toward rvalid_o.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_entry_t;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bus_mem_responder_resp_pipe.sv
// Fixed-latency response shift pipeline. An entry pushed at a clock edge
// appears on head after STAGES-1 further edges. Only the valid bits are
// reset, so a reset flushes everything in flight; payload is gated by valid.
module bus_resp_pipe
  import bus_mem_responder_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  resp_entry_t push,
  output resp_entry_t head
);

  logic        vld_p   [STAGES];
  logic        err_p   [STAGES];
  logic [31:0] rdata_p [STAGES];

  // Valid bits shift every cycle and are cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= push.valid;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Payload shifts alongside the valid bits without a reset.
  always_ff @(posedge clk_i) begin
    err_p[0]   <= push.err;
    rdata_p[0] <= push.rdata;
    for (int i = 1; i < STAGES; i++) begin
      err_p[i]   <= err_p[i-1];
      rdata_p[i] <= rdata_p[i-1];
    end
  end

  // Present the last stage, forcing payload to zero when no response is due.
  always_comb begin
    head       = '0;
    head.valid = vld_p[STAGES-1];
    head.err   = vld_p[STAGES-1] & err_p[STAGES-1];
    head.rdata = vld_p[STAGES-1] ? rdata_p[STAGES-1] : 32'h0;
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Word-organised memory behind a simple req/gnt bus with a configurable
// grant delay and a fixed response latency. Every granted transaction
// produces exactly one rvalid_o pulse, in grant order, with no backpressure.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int Depth     = 1024,
  parameter int GntDelay  = 0,
  parameter int RespDelay = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(Depth);
  localparam logic [1:0] GntLim = 2'(GntDelay);
  localparam int RespStages = (RespDelay > MaxRespDelay) ? MaxRespDelay :
                              (RespDelay < 1) ? 1 : RespDelay;

  gnt_state_t  state;
  logic [1:0]  wait_cnt;
  logic [1:0]  cnt_next;
  gnt_state_t  state_next;
  logic        gnt;
  logic        addr_err;
  logic [AW-1:0] idx;
  logic [31:0] mem [Depth];
  resp_entry_t push;
  resp_entry_t head;

  // Count toward the grant delay, stopping at the limit.
  function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] lim);
    return (v >= lim) ? lim : v + 2'd1;
  endfunction

  // Grant when the request has been held long enough and nobody stalls it.
  assign gnt   = req_i & ~stall_i & (wait_cnt == GntLim) & ~rst_i;
  assign gnt_o = gnt;

  // Next wait count and state: clear on grant or dropped request, hold on stall.
  always_comb begin
    cnt_next   = wait_cnt;
    state_next = state;
    if (!req_i || gnt) begin
      cnt_next   = 2'd0;
      state_next = GNT_IDLE;
    end else begin
      if (!stall_i && state != GNT_READY) cnt_next = sat_inc(wait_cnt, GntLim);
      state_next = (cnt_next == GntLim) ? GNT_READY : GNT_WAIT;
    end
  end

  // Grant FSM state and wait counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= GNT_IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
    end
  end

  // Misaligned or beyond-the-array accesses are errors.
  assign idx      = addr_i[AW+1:2];
  assign addr_err = (addr_i[1:0] != 2'b00) || ({2'b00, addr_i[31:2]} >= 32'(Depth));

  // Byte-masked writes commit at the grant edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (gnt && we_i && !addr_err) mem[idx] <= byte_merge(mem[idx], wdata_i, be_i);
  end

  // Build the response from the word as it stands at the grant edge.
  always_comb begin
    push       = '0;
    push.valid = gnt;
    push.err   = gnt & addr_err;
    push.rdata = (gnt && !we_i && !addr_err) ? mem[idx] : 32'h0;
  end

  bus_resp_pipe #(
    .STAGES (RespStages)
  ) u_resp_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .head  (head)
  );

  assign rvalid_o = head.valid;
  assign rdata_o  = head.rdata;
  assign err_o    = head.err;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder using three configurations:
//   a: GntDelay=0, RespDelay=1   b: GntDelay=0, RespDelay=3   c: GntDelay=2, RespDelay=1
module tb_bus_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall = 1'b0;

  logic        gnt_a, gnt_b, gnt_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        err_a, err_b, err_c;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_mem_responder #(.Depth(16), .GntDelay(0), .RespDelay(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .gnt_o(gnt_a), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .stall_i(stall), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .err_o(err_a));

  bus_mem_responder #(.Depth(16), .GntDelay(0), .RespDelay(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .stall_i(stall), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .err_o(err_b));

  bus_mem_responder #(.Depth(16), .GntDelay(2), .RespDelay(1)) dut_c (
    .clk_i(clk), .rst_i(rst), .req_i(req_c), .gnt_o(gnt_c), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .stall_i(stall), .rvalid_o(rvalid_c),
    .rdata_o(rdata_c), .err_o(err_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d);
    we = w; be = b; addr = a; wdata = d;
  endtask

  initial begin
    // Reset state, with a request pending that must not be granted.
    req_a = 1'b1;
    neg();
    check("rst_gnt_a",    32'(gnt_a), 32'd0);
    check("rst_rvalid_a", 32'(rvalid_a), 32'd0);
    check("rst_rdata_b",  rdata_b, 32'h0);
    check("rst_err_c",    32'(err_c), 32'd0);
    req_a = 1'b0;
    step();
    rst = 1'b0;

    // a: write 0xDEADBEEF to 0x10 then read it back.
    step(); drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF); req_a = 1'b1;
    neg(); check("a_wr_gnt_same_cycle", 32'(gnt_a), 32'd1);
    check("a_no_rvalid_yet", 32'(rvalid_a), 32'd0);
    step(); drive(1'b0, 4'hF, 32'h10, 32'h0);
    neg(); check("a_rd_gnt_b2b", 32'(gnt_a), 32'd1);
    check("a_wr_rvalid", 32'(rvalid_a), 32'd1);
    check("a_wr_rdata_zero", rdata_a, 32'h0);
    step(); req_a = 1'b0;
    neg(); check("a_rd_rvalid", 32'(rvalid_a), 32'd1);
    check("a_rd_rdata", rdata_a, 32'hDEADBEEF);
    check("a_rd_err", 32'(err_a), 32'd0);
    step();
    neg(); check("a_rvalid_single_pulse", 32'(rvalid_a), 32'd0);

    // a: partial write with be=0x5 over a cleared word.
    step(); drive(1'b1, 4'hF, 32'h20, 32'h0); req_a = 1'b1;
    step(); drive(1'b1, 4'h5, 32'h20, 32'h11223344);
    step(); drive(1'b0, 4'hF, 32'h20, 32'h0);
    step(); req_a = 1'b0;
    neg(); check("a_be_rvalid", 32'(rvalid_a), 32'd1);
    check("a_be_rdata", rdata_a, 32'h00220044);

    // a: out-of-range and misaligned accesses, memory must stay unchanged.
    step(); drive(1'b0, 4'hF, 32'h40, 32'h0); req_a = 1'b1;
    neg(); check("a_err_gnt", 32'(gnt_a), 32'd1);
    step(); drive(1'b0, 4'hF, 32'h2, 32'h0);
    neg(); check("a_oob_rvalid", 32'(rvalid_a), 32'd1);
    check("a_oob_err", 32'(err_a), 32'd1);
    check("a_oob_rdata", rdata_a, 32'h0);
    step(); drive(1'b1, 4'hF, 32'h12, 32'h12345678);
    neg(); check("a_mis_err", 32'(err_a), 32'd1);
    check("a_mis_rdata", rdata_a, 32'h0);
    step(); drive(1'b0, 4'hF, 32'h10, 32'h0);
    neg(); check("a_mis_wr_err", 32'(err_a), 32'd1);
    step(); req_a = 1'b0;
    neg(); check("a_mem_unchanged_err", 32'(err_a), 32'd0);
    check("a_mem_unchanged", rdata_a, 32'hDEADBEEF);
    step();
    neg(); check("a_idle_rdata", rdata_a, 32'h0);
    check("a_idle_err", 32'(err_a), 32'd0);

    // b: three writes then three back-to-back reads with RespDelay=3.
    step(); drive(1'b1, 4'hF, 32'h0, 32'hA1A1A1A1); req_b = 1'b1;
    neg(); check("b_gnt", 32'(gnt_b), 32'd1);
    step(); drive(1'b1, 4'hF, 32'h4, 32'hB2B2B2B2);
    neg(); check("b_lat_0", 32'(rvalid_b), 32'd0);
    step(); drive(1'b1, 4'hF, 32'h8, 32'hC3C3C3C3);
    neg(); check("b_lat_1", 32'(rvalid_b), 32'd0);
    step(); drive(1'b0, 4'hF, 32'h0, 32'h0);
    neg(); check("b_wr0_rvalid", 32'(rvalid_b), 32'd1);
    step(); drive(1'b0, 4'hF, 32'h4, 32'h0);
    neg(); check("b_wr1_rvalid", 32'(rvalid_b), 32'd1);
    step(); drive(1'b0, 4'hF, 32'h8, 32'h0);
    neg(); check("b_wr2_rvalid", 32'(rvalid_b), 32'd1);
    step(); req_b = 1'b0;
    neg(); check("b_rd0_rvalid", 32'(rvalid_b), 32'd1);
    check("b_rd0_rdata", rdata_b, 32'hA1A1A1A1);
    step();
    neg(); check("b_rd1_rvalid", 32'(rvalid_b), 32'd1);
    check("b_rd1_rdata", rdata_b, 32'hB2B2B2B2);
    step();
    neg(); check("b_rd2_rvalid", 32'(rvalid_b), 32'd1);
    check("b_rd2_rdata", rdata_b, 32'hC3C3C3C3);
    step();
    neg(); check("b_drained", 32'(rvalid_b), 32'd0);

    // b: stall holds off the grant.
    step(); drive(1'b0, 4'hF, 32'h0, 32'h0); req_b = 1'b1; stall = 1'b1;
    neg(); check("b_stall_gnt0", 32'(gnt_b), 32'd0);
    step();
    neg(); check("b_stall_gnt1", 32'(gnt_b), 32'd0);
    step(); stall = 1'b0;
    neg(); check("b_unstall_gnt", 32'(gnt_b), 32'd1);
    step(); req_b = 1'b0;
    neg(); check("b_stall_lat0", 32'(rvalid_b), 32'd0);
    step();
    neg(); check("b_stall_lat1", 32'(rvalid_b), 32'd0);
    step();
    neg(); check("b_stall_rvalid", 32'(rvalid_b), 32'd1);
    check("b_stall_rdata", rdata_b, 32'hA1A1A1A1);

    // b: reset with two reads in flight flushes them.
    step(); drive(1'b0, 4'hF, 32'h4, 32'h0); req_b = 1'b1;
    step(); drive(1'b0, 4'hF, 32'h8, 32'h0);
    step(); req_b = 1'b0;
    step();
    check("b_pre_rst_rvalid", 32'(rvalid_b), 32'd1);
    rst = 1'b1;
    #1;
    check("b_rst_rvalid_now", 32'(rvalid_b), 32'd0);
    check("b_rst_rdata_now", rdata_b, 32'h0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      neg(); check("b_post_rst_no_rvalid", 32'(rvalid_b), 32'd0);
      step();
    end

    // c: GntDelay=2 grants on the third held cycle; dropping req restarts.
    drive(1'b0, 4'hF, 32'h0, 32'h0); req_c = 1'b1;
    neg(); check("c_gnt_cyc1", 32'(gnt_c), 32'd0);
    step();
    neg(); check("c_gnt_cyc2", 32'(gnt_c), 32'd0);
    step();
    neg(); check("c_gnt_cyc3", 32'(gnt_c), 32'd1);
    step(); req_c = 1'b0;
    neg(); check("c_after_gnt_rvalid", 32'(rvalid_c), 32'd1);
    step(); req_c = 1'b1;
    neg(); check("c_partial_cyc1", 32'(gnt_c), 32'd0);
    step(); req_c = 1'b0;
    neg(); check("c_dropped", 32'(gnt_c), 32'd0);
    step(); req_c = 1'b1;
    neg(); check("c_restart_cyc1", 32'(gnt_c), 32'd0);
    step();
    neg(); check("c_restart_cyc2", 32'(gnt_c), 32'd0);
    step();
    neg(); check("c_restart_cyc3", 32'(gnt_c), 32'd1);
    step(); req_c = 1'b0;
    neg(); check("c_idle_gnt", 32'(gnt_c), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
